rotate_pipe: RTL and testbench

// - Pipelined, parametrised barrel shifter/rotator; successor to the single-cycle rotator.
// - Ops: rotate left/right, logical shift left/right, arithmetic shift right.
// - valid/ready flow control on both sides; sits between a producer and consumer datapath.
// - log2(W) shift levels spread over STAGES register stages.

---
 rtl/rotate_pipe.sv | 208 ++++++++++++++++++++
 tb/tb_rotate_pipe.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotate_pipe.sv
// rotate_pipe: pipelined, parametrised barrel shifter / rotator.
//
// Ops: rotate left/right, logical shift left/right and arithmetic shift right.
// The log2(W) shift levels are spread evenly over STAGES register stages.
// A beat accepted on a rising edge is presented on out_valid STAGES edges
// after it was first driven, assuming no stall. Flow control is valid/ready
// on both sides, and the block sustains one beat per cycle.
//
// Parameters:
//   W       data width (power of 2, >= 4)
//   STAGES  register stages, 1..$clog2(W)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   block can accept a beat (combinational on out_ready)
//   in_x       operand
//   in_n       shift/rotate amount, $clog2(W)+1 bits
//   in_op      0 ROL, 1 ROR, 2 SHL, 3 SHR, 4 SRA, 5..7 reserved
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_y      result (0 while !out_valid)
//   out_err    beat carried a reserved op
//   out_cnt    count of output handshakes (only with ROTATE_PIPE_CNT_EN)
//
// Configuration macro: ROTATE_PIPE_CNT_EN adds the out_cnt port and counter.

module rotate_pipe #(
  parameter int W      = 32,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_x,
  input  logic [$clog2(W):0] in_n,
  input  logic [2:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_y,
  output logic               out_err
`ifdef ROTATE_PIPE_CNT_EN
  ,
  output logic [31:0]        out_cnt
`endif
);

  localparam int L    = $clog2(W);
  localparam int LAST = STAGES - 1;

  typedef enum logic [2:0] {
    OP_ROL = 3'd0,
    OP_ROR = 3'd1,
    OP_SHL = 3'd2,
    OP_SHR = 3'd3,
    OP_SRA = 3'd4
  } op_e;

  function automatic logic [W-1:0] bitrev(input logic [W-1:0] a);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = a[W-1-i];
    return r;
  endfunction

  // Decoded input beat
  logic [W-1:0] pre_d;
  logic [L-1:0] pre_amt;
  logic         pre_rot, pre_right, pre_fill, pre_big, pre_err;

  // Pipeline state and per-stage views
  logic [STAGES-1:0] v, vin;
  logic [STAGES:0]   ready;
  logic [W-1:0]      d_q   [STAGES];
  logic [W-1:0]      s_d   [STAGES];
  logic [W-1:0]      d_nx  [STAGES];
  logic [L-1:0]      amt_q [STAGES];
  logic [L-1:0]      s_amt [STAGES];
  logic [STAGES-1:0] fill_q, rot_q, right_q, big_q, err_q;
  logic [STAGES-1:0] s_fill, s_rot, s_right, s_big, s_err;
  logic [W-1:0]      y_post;

  // Right-hand ops are done as left ops on the bit-reversed operand and the
  // result is reversed back at the output. The SRA fill bit is captured
  // here, before reversal, so it travels with the beat.
  always_comb begin
    pre_rot   = 1'b0;
    pre_right = 1'b0;
    pre_fill  = 1'b0;
    pre_err   = 1'b0;
    case (in_op)
      OP_ROL: pre_rot = 1'b1;
      OP_ROR: begin
        pre_rot   = 1'b1;
        pre_right = 1'b1;
      end
      OP_SHL: ;
      OP_SHR: pre_right = 1'b1;
      OP_SRA: begin
        pre_right = 1'b1;
        pre_fill  = in_x[W-1];
      end
      default: pre_err = 1'b1;
    endcase
    pre_d   = pre_right ? bitrev(in_x) : in_x;
    pre_amt = in_n[L-1:0];
    pre_big = in_n[L];
  end

  // Stage k takes its inputs from the decoder (k=0) or from stage k-1.
  always_comb begin
    s_d[0]     = pre_d;
    s_amt[0]   = pre_amt;
    s_fill[0]  = pre_fill;
    s_rot[0]   = pre_rot;
    s_right[0] = pre_right;
    s_big[0]   = pre_big;
    s_err[0]   = pre_err;
    vin[0]     = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      s_d[k]     = d_q[k-1];
      s_amt[k]   = amt_q[k-1];
      s_fill[k]  = fill_q[k-1];
      s_rot[k]   = rot_q[k-1];
      s_right[k] = right_q[k-1];
      s_big[k]   = big_q[k-1];
      s_err[k]   = err_q[k-1];
      vin[k]     = v[k-1];
    end
  end

  // Stage k applies levels [k*L/STAGES, (k+1)*L/STAGES). Shifts pull in the
  // fill bit from the right; rotates wrap the top bits around.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      d_nx[k] = s_d[k];
      for (int j = 0; j < L; j++) begin
        if (j >= (k * L) / STAGES && j < ((k + 1) * L) / STAGES && s_amt[k][j]) begin
          if (s_rot[k])
            d_nx[k] = (d_nx[k] << (1 << j)) | (d_nx[k] >> (W - (1 << j)));
          else
            d_nx[k] = (d_nx[k] << (1 << j)) |
                      (s_fill[k] ? ~({W{1'b1}} << (1 << j)) : '0);
        end
      end
    end
  end

  // A stage can load when it is empty or its content moves on this edge;
  // the chain runs from the consumer back to the input.
  always_comb begin
    ready[STAGES] = out_ready;
    for (int k = LAST; k >= 0; k--) ready[k] = !v[k] || ready[k+1];
  end

  assign in_ready = ready[0];

  // Oversized shifts collapse to the fill bit; rotates already wrapped mod W.
  always_comb begin
    if (err_q[LAST])
      y_post = '0;
    else if (big_q[LAST] && !rot_q[LAST])
      y_post = {W{fill_q[LAST]}};
    else if (right_q[LAST])
      y_post = bitrev(d_q[LAST]);
    else
      y_post = d_q[LAST];
  end

  assign out_valid = v[LAST];
  assign out_y     = v[LAST] ? y_post : '0;
  assign out_err   = v[LAST] && err_q[LAST];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++)
        if (ready[k]) v[k] <= vin[k];
    end
  end

  // Data registers carry no reset; the outputs are masked by out_valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (ready[k] && vin[k]) begin
        d_q[k]     <= d_nx[k];
        amt_q[k]   <= s_amt[k];
        fill_q[k]  <= s_fill[k];
        rot_q[k]   <= s_rot[k];
        right_q[k] <= s_right[k];
        big_q[k]   <= s_big[k];
        err_q[k]   <= s_err[k];
      end
    end
  end

`ifdef ROTATE_PIPE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out_cnt <= '0;
    else if (out_valid && out_ready)
      out_cnt <= out_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_rotate_pipe.sv
// tb_rotate_pipe: self-checking bench for rotate_pipe (W=8, STAGES=2).
// Expected results are queued when a beat is accepted and compared when
// the DUT hands a result over. Honours ROTATE_PIPE_CNT_EN when defined.

module tb_rotate_pipe;

  localparam int W  = 8;
  localparam int STAGES = 2;
  localparam int NW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_x = '0;
  logic [NW-1:0] in_n = '0;
  logic [2:0]    in_op = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_y;
  logic          out_err;
`ifdef ROTATE_PIPE_CNT_EN
  logic [31:0]   out_cnt;
`endif

  int         checks = 0;
  int         passes = 0;
  int         fails = 0;
  int         hs_count = 0;
  bit         rand_bp = 1'b0;
  logic [W:0] sb[$];

  always #5 clk = ~clk;

  rotate_pipe #(.W(W), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_n      (in_n),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_err   (out_err)
`ifdef ROTATE_PIPE_CNT_EN
    ,
    .out_cnt   (out_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bit-level reference: {err, y}
  function automatic logic [W:0] model(input logic [W-1:0] x, input int n, input int op);
    logic [W-1:0] y;
    int r;
    y = '0;
    r = n % W;
    case (op)
      0: for (int i = 0; i < W; i++) y[i] = x[(i - r + W) % W];
      1: for (int i = 0; i < W; i++) y[i] = x[(i + r) % W];
      2: for (int i = 0; i < W; i++) if (i >= n) y[i] = x[i - n];
      3: for (int i = 0; i < W; i++) if (i + n < W) y[i] = x[i + n];
      4: for (int i = 0; i < W; i++) y[i] = (i + n < W) ? x[i + n] : x[W-1];
      default: return {1'b1, {W{1'b0}}};
    endcase
    return {1'b0, y};
  endfunction

  task automatic checkOutput();
    logic [W:0] e;
    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("out_y", 32'(out_y), 32'(e[W-1:0]));
      check("out_err", 32'(out_err), 32'(e[W]));
    end
    hs_count++;
  endtask

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) checkOutput();

  // Drives one beat and holds it until accepted; returns just after the
  // accepting edge with in_valid still high so beats can go back to back.
  task automatic applyStimulus(input logic [W-1:0] x, input logic [NW-1:0] n,
                               input logic [2:0] op, input logic [W:0] exp,
                               output int waited);
    waited = 0;
    in_valid = 1'b1;
    in_x = x;
    in_n = n;
    in_op = op;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
      waited++;
      @(negedge clk);
    end
    check("accept", 32'(in_ready), 32'd1);
    if (in_ready) sb.push_back(exp);
    @(posedge clk);
    #1;
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && c < 200) begin
      @(posedge clk);
      c++;
    end
    #1;
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic checkCount();
`ifdef ROTATE_PIPE_CNT_EN
    check("out_cnt", out_cnt, 32'(hs_count));
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    int lat;
    int waits;
    int h0;
    logic [W-1:0] rx;
    int rn, rop;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_y", 32'(out_y), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    checkCount();

    // Latency: ROL 0x81 by 1 appears two cycles after it is driven
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_x = 8'h81;
    in_n = 4'd1;
    in_op = 3'd0;
    @(negedge clk);
    check("lat_accept", 32'(in_ready), 32'd1);
    sb.push_back({1'b0, 8'h03});
    @(posedge clk);
    #1;
    idle();
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", 32'(lat), 32'(STAGES));
    drain();

    // Directed ops and amount boundaries
    applyStimulus(8'h81, 4'd1,  3'd1, {1'b0, 8'hC0}, w);
    applyStimulus(8'h80, 4'd3,  3'd4, {1'b0, 8'hF0}, w);
    applyStimulus(8'h80, 4'd3,  3'd3, {1'b0, 8'h10}, w);
    applyStimulus(8'hFF, 4'd8,  3'd2, {1'b0, 8'h00}, w);
    applyStimulus(8'h80, 4'd15, 3'd4, {1'b0, 8'hFF}, w);
    applyStimulus(8'h81, 4'd9,  3'd0, {1'b0, 8'h03}, w);
    applyStimulus(8'h5A, 4'd2,  3'd6, {1'b1, 8'h00}, w);
    applyStimulus(8'hA5, 4'd0,  3'd0, {1'b0, 8'hA5}, w);
    applyStimulus(8'hA5, 4'd0,  3'd4, {1'b0, 8'hA5}, w);
    applyStimulus(8'h3C, 4'd0,  3'd3, {1'b0, 8'h3C}, w);
    applyStimulus(8'h81, 4'd8,  3'd1, {1'b0, 8'h81}, w);
    applyStimulus(8'h80, 4'd8,  3'd3, {1'b0, 8'h00}, w);
    applyStimulus(8'h7F, 4'd12, 3'd4, {1'b0, 8'h00}, w);
    applyStimulus(8'hC3, 4'd4,  3'd7, {1'b1, 8'h00}, w);
    applyStimulus(8'h96, 4'd3,  3'd2, {1'b0, 8'hB0}, w);
    idle();
    drain();
    @(negedge clk);
    check("idle_out_y", 32'(out_y), 32'd0);
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // Back-to-back: 16 beats, one per cycle, no stall
    waits = 0;
    h0 = hs_count;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      rx = W'($urandom);
      rn = $urandom_range(0, 15);
      rop = $urandom_range(0, 4);
      applyStimulus(rx, NW'(rn), 3'(rop), model(rx, rn, rop), w);
      waits += w;
    end
    idle();
    check("b2b_no_stall", 32'(waits), 32'd0);
    repeat (STAGES) @(posedge clk);
    #1;
    check("b2b_throughput", 32'(hs_count - h0), 32'd16);
    drain();

    // Backpressure: pipe fills after two beats, data held, nothing lost
    out_ready = 1'b0;
    applyStimulus(8'h01, 4'd1, 3'd0, {1'b0, 8'h02}, w);
    applyStimulus(8'h01, 4'd1, 3'd1, {1'b0, 8'h80}, w);
    h0 = hs_count;
    in_valid = 1'b1;
    in_x = 8'h0F;
    in_n = 4'd4;
    in_op = 3'd2;
    @(negedge clk);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_head_y", 32'(out_y), 32'h02);
    repeat (3) @(negedge clk);
    check("bp_still_full", 32'(in_ready), 32'd0);
    check("bp_head_held", 32'(out_y), 32'h02);
    check("bp_no_output", 32'(hs_count - h0), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(8'h0F, 4'd4, 3'd2, {1'b0, 8'hF0}, w);
    idle();
    drain();
    checkCount();

    // Random ops/amounts with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 200; i++) begin
      rx = W'($urandom);
      rn = $urandom_range(0, 15);
      rop = $urandom_range(0, 7);
      applyStimulus(rx, NW'(rn), 3'(rop), model(rx, rn, rop), w);
    end
    rand_bp = 1'b0;
    idle();
    drain();
    checkCount();

    // Reset with two beats in flight
    out_ready = 1'b0;
    applyStimulus(8'h11, 4'd1, 3'd0, {1'b0, 8'h22}, w);
    applyStimulus(8'h22, 4'd1, 3'd0, {1'b0, 8'h44}, w);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_y", 32'(out_y), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    hs_count = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_no_stale", 32'(out_valid), 32'd0);
    check("post_rst_no_hs", 32'(hs_count), 32'd0);
    checkCount();

    // Traffic after reset
    @(posedge clk);
    #1;
    applyStimulus(8'h81, 4'd1, 3'd0, {1'b0, 8'h03}, w);
    applyStimulus(8'h80, 4'd3, 3'd4, {1'b0, 8'hF0}, w);
    applyStimulus(8'h80, 4'd3, 3'd3, {1'b0, 8'h10}, w);
    idle();
    drain();
    checkCount();
    check("post_rst_hs", 32'(hs_count), 32'd3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
